// File: rtl/inv_add_round_key_block_if.sv
// Bus bundle for inv_add_round_key_block: key load, state-block input and key-added output.
// round_key_out exists only when INV_ARK_KEY_OUT_EN is defined.
`ifndef SEED_KEY_WIDTH
`define SEED_KEY_WIDTH 128
`endif
`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 128
`endif

interface inv_add_round_key_block_if #(parameter int RIDX_W = 4);
  logic [`SEED_KEY_WIDTH-1:0]   seed_key;
  logic                         seed_key_vld;
  logic [`BLOCK_DATA_WIDTH-1:0] data_in;
  logic                         data_in_vld;
  logic [`BLOCK_DATA_WIDTH-1:0] block_data_out;
  logic                         block_data_out_vld;
  logic [RIDX_W-1:0]            round_idx;
  logic                         key_ready;
  logic                         drop_err;
`ifdef INV_ARK_KEY_OUT_EN
  logic [`BLOCK_DATA_WIDTH-1:0] round_key_out;
`endif

  modport master (
    output seed_key, seed_key_vld, data_in, data_in_vld,
    input  block_data_out, block_data_out_vld, round_idx, key_ready, drop_err
`ifdef INV_ARK_KEY_OUT_EN
    , input round_key_out
`endif
  );

  modport slave (
    input  seed_key, seed_key_vld, data_in, data_in_vld,
    output block_data_out, block_data_out_vld, round_idx, key_ready, drop_err
`ifdef INV_ARK_KEY_OUT_EN
    , output round_key_out
`endif
  );
endinterface

// File: rtl/inv_add_round_key_block.sv
// AES-128 key expander plus reverse-order round-key adder for the inverse cipher.
// Define INV_ARK_KEY_OUT_EN to also register out the round key applied to each block.
`ifndef SEED_KEY_WIDTH
`define SEED_KEY_WIDTH 128
`endif
`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 128
`endif

// Forward S-box: multiplicative inverse in GF(2^8) (as a^254) followed by the affine map.
module inv_ark_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;

  always_comb begin
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module inv_add_round_key_block #(
  parameter int NUM_ROUNDS = 10,
  parameter int RIDX_W     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  inv_add_round_key_block_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t                       state, state_nxt;
  logic [RIDX_W-1:0]            exp_cnt;
  logic [7:0]                   rcon;
  logic [`BLOCK_DATA_WIDTH-1:0] rk [0:NUM_ROUNDS];
  logic                         load_key, expand_en, accept, drop, last_step;

  logic [`BLOCK_DATA_WIDTH-1:0] out_q;
  logic                         out_vld_q;
  logic [RIDX_W-1:0]            ridx_q;
  logic                         key_ready_q;
  logic                         drop_err_q;

  // Key schedule step: rk[exp_cnt] from rk[exp_cnt-1]
  logic [`BLOCK_DATA_WIDTH-1:0] prev_key, next_key;
  logic [3:0][7:0]              sb_in, sb_out;
  logic [31:0]                  temp, w0, w1, w2, w3;

  assign prev_key = rk[exp_cnt - 1'b1];
  assign sb_in    = {prev_key[23:0], prev_key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    inv_ark_sbox u_sbox (.a(sb_in[b]), .s(sb_out[b]));
  end

  assign temp     = sb_out ^ {rcon, 24'h0};
  assign w0       = prev_key[127:96] ^ temp;
  assign w1       = w0 ^ prev_key[95:64];
  assign w2       = w1 ^ prev_key[63:32];
  assign w3       = w2 ^ prev_key[31:0];
  assign next_key = {w0, w1, w2, w3};

  assign last_step = (exp_cnt == RIDX_W'(NUM_ROUNDS));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.seed_key_vld)                  state_nxt = EXPAND;
    else if (state == EXPAND && last_step) state_nxt = READY;
  end

  // A key load wins over any data strobe in the same cycle; that data is silently lost.
  always_comb begin
    load_key  = bus.seed_key_vld;
    expand_en = !bus.seed_key_vld && (state == EXPAND);
    accept    = !bus.seed_key_vld && bus.data_in_vld && (state == READY);
    drop      = !bus.seed_key_vld && bus.data_in_vld && (state != READY);
  end

  // Key store has no reset; its contents are only read once rewritten by a load.
  always_ff @(posedge clock) begin
    if (load_key)       rk[0]       <= bus.seed_key;
    else if (expand_en) rk[exp_cnt] <= next_key;
  end

`ifdef INV_ARK_KEY_OUT_EN
  logic [`BLOCK_DATA_WIDTH-1:0] rk_out_q;
  assign bus.round_key_out = rk_out_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_cnt     <= '0;
      rcon        <= '0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      ridx_q      <= RIDX_W'(NUM_ROUNDS);
      key_ready_q <= 1'b0;
      drop_err_q  <= 1'b0;
`ifdef INV_ARK_KEY_OUT_EN
      rk_out_q    <= '0;
`endif
    end else begin
      out_vld_q <= accept;
      if (load_key) begin
        exp_cnt     <= RIDX_W'(1);
        rcon        <= 8'h01;
        key_ready_q <= 1'b0;
        drop_err_q  <= 1'b0;
        ridx_q      <= RIDX_W'(NUM_ROUNDS);
      end else begin
        if (expand_en) begin
          exp_cnt <= exp_cnt + 1'b1;
          rcon    <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (last_step) key_ready_q <= 1'b1;
        end
        if (drop) drop_err_q <= 1'b1;
        if (accept) begin
          out_q  <= bus.data_in ^ rk[ridx_q];
          ridx_q <= (ridx_q == '0) ? RIDX_W'(NUM_ROUNDS) : ridx_q - 1'b1;
`ifdef INV_ARK_KEY_OUT_EN
          rk_out_q <= rk[ridx_q];
`endif
        end
      end
    end
  end

  assign bus.block_data_out     = out_q;
  assign bus.block_data_out_vld = out_vld_q;
  assign bus.round_idx          = ridx_q;
  assign bus.key_ready          = key_ready_q;
  assign bus.drop_err           = drop_err_q;
endmodule

// File: tb/tb_inv_add_round_key_block.sv
// Randomized bench for inv_add_round_key_block against a cycle-level behavioural model
// built from the FIPS-197 word-oriented key schedule with a generator-derived S-box table.
module tb_inv_add_round_key_block;
  localparam int NR = 10;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  inv_add_round_key_block_if #(.RIDX_W(4)) bus();
  inv_add_round_key_block #(.NUM_ROUNDS(NR), .RIDX_W(4)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] m_rk [0:NR];
  logic [127:0] m_out, m_key;
  logic         m_vld, m_kr, m_drop, m_ready;
  int           m_idx, m_exp_left;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK10_K2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  // S-box from walking GF(2^8) with generator 3 and its inverse in lockstep.
  function automatic void build_sbox();
    logic [7:0] p = 8'h01;
    logic [7:0] q = 8'h01;
    logic [7:0] x;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endfunction

  function automatic void m_expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic void m_reset();
    m_out = '0; m_key = '0; m_vld = 1'b0; m_kr = 1'b0; m_drop = 1'b0;
    m_ready = 1'b0; m_idx = NR; m_exp_left = 0;
  endfunction

  task automatic check_outs(input string t);
    chk({t, ".vld"},  128'(bus.block_data_out_vld), 128'(m_vld));
    chk({t, ".data"}, bus.block_data_out, m_out);
    chk({t, ".ridx"}, 128'(bus.round_idx), 128'(m_idx));
    chk({t, ".krdy"}, 128'(bus.key_ready), 128'(m_kr));
    chk({t, ".derr"}, 128'(bus.drop_err), 128'(m_drop));
`ifdef INV_ARK_KEY_OUT_EN
    chk({t, ".rkey"}, bus.round_key_out, m_key);
`endif
  endtask

  // Entered and left at posedge+1: drives one cycle of inputs, advances the model, checks.
  task automatic cycle(input string t, input logic sv, input logic [127:0] sk,
                       input logic dv, input logic [127:0] din);
    bus.seed_key_vld = sv; bus.seed_key = sk;
    bus.data_in_vld  = dv; bus.data_in  = din;
    @(posedge clock); #1;
    m_vld = 1'b0;
    if (sv) begin
      m_expand(sk);
      m_exp_left = NR; m_ready = 1'b0; m_kr = 1'b0; m_drop = 1'b0; m_idx = NR;
    end else begin
      if (dv) begin
        if (m_ready) begin
          m_out = din ^ m_rk[m_idx];
          m_key = m_rk[m_idx];
          m_vld = 1'b1;
          m_idx = (m_idx == 0) ? NR : m_idx - 1;
        end else m_drop = 1'b1;
      end
      if (m_exp_left > 0) begin
        m_exp_left--;
        if (m_exp_left == 0) begin m_ready = 1'b1; m_kr = 1'b1; end
      end
    end
    bus.seed_key_vld = 1'b0; bus.data_in_vld = 1'b0;
    check_outs(t);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    build_sbox();
    m_reset();
    bus.seed_key = '0; bus.seed_key_vld = 1'b0; bus.data_in = '0; bus.data_in_vld = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_outs("reset");
    reset = 1'b0;

    // 1: known-answer with FIPS-197 appendix key
    cycle("t1_load", 1'b1, KEY1, 1'b0, '0);
    cyc = 0;
    while (!bus.key_ready && cyc < 20) begin
      cycle("t1_exp", 1'b0, '0, 1'b0, '0);
      cyc++;
    end
    chk("t1_kr_latency", 128'(cyc), 128'(10));
    cycle("t1_data", 1'b0, '0, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("t1_kat", bus.block_data_out, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
`ifdef INV_ARK_KEY_OUT_EN
    chk("t1_kat_key", bus.round_key_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
`endif

    // 2: rk10 of the classic key
    cycle("t2_load", 1'b1, KEY2, 1'b0, '0);
    repeat (10) cycle("t2_exp", 1'b0, '0, 1'b0, '0);
    cycle("t2_data", 1'b0, '0, 1'b1, '0);
    chk("t2_kat_rk10", bus.block_data_out, RK10_K2);

    // 3: full back-to-back sweep rk10..rk0 and wrap
    cycle("t3_load", 1'b1, KEY2, 1'b0, '0);
    repeat (10) cycle("t3_exp", 1'b0, '0, 1'b0, '0);
    for (int k = 0; k <= NR; k++) cycle("t3_b2b", 1'b0, '0, 1'b1, '0);
    chk("t3_last_rk0", bus.block_data_out, KEY2);
    chk("t3_wrap_idx", 128'(bus.round_idx), 128'(10));
    cycle("t3_12th", 1'b0, '0, 1'b1, '0);
    chk("t3_12th_rk10", bus.block_data_out, RK10_K2);

    // 4: data during expansion is dropped, flag cleared by next load
    cycle("t4_load", 1'b1, KEY1, 1'b0, '0);
    cycle("t4_exp", 1'b0, '0, 1'b0, '0);
    cycle("t4_drop", 1'b0, '0, 1'b1, rnd128());
    chk("t4_drop_flag", 128'(bus.drop_err), 128'(1));
    chk("t4_drop_novld", 128'(bus.block_data_out_vld), 128'(0));
    cycle("t4_reload", 1'b1, KEY1, 1'b0, '0);
    chk("t4_drop_clr", 128'(bus.drop_err), 128'(0));
    repeat (10) cycle("t4_exp", 1'b0, '0, 1'b0, '0);

    // 5: load and data together in READY
    cycle("t5_both", 1'b1, KEY2, 1'b1, rnd128());
    chk("t5_novld", 128'(bus.block_data_out_vld), 128'(0));
    repeat (10) cycle("t5_exp", 1'b0, '0, 1'b0, '0);
    chk("t5_ready", 128'(bus.key_ready), 128'(1));

    // 6: async reset during expansion
    cycle("t6_load", 1'b1, KEY1, 1'b0, '0);
    cycle("t6_exp", 1'b0, '0, 1'b1, '0);
    repeat (3) cycle("t6_exp", 1'b0, '0, 1'b0, '0);
    #2 reset = 1'b1;
    #1;
    m_reset();
    check_outs("t6_async");
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (3) cycle("t6_idle", 1'b0, '0, 1'b0, '0);
    cycle("t6_idle_drop", 1'b0, '0, 1'b1, rnd128());
    repeat (12) cycle("t6_idle", 1'b0, '0, 1'b0, '0);

    // Randomized traffic
    cycle("rnd_load", 1'b1, rnd128(), 1'b0, '0);
    for (int n = 0; n < 400; n++) begin
      logic sv;
      logic dv;
      sv = ($urandom_range(0, 59) == 0);
      dv = ($urandom_range(0, 2) != 0);
      cycle("rnd", sv, rnd128(), dv, rnd128());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
